// File: rtl/rev_pkg.sv
// Shared types for the reversible cascade engine: gate opcodes, the packed
// gate word written into the program memory, and the engine FSM states.
package rev_pkg;

    localparam int REV_WIDTH = 8;
    localparam int REV_DEPTH = 16;
    localparam int IDX_W     = $clog2(REV_WIDTH);

    typedef enum logic [1:0] {
        NOT     = 2'd0,
        CNOT    = 2'd1,
        TOFFOLI = 2'd2,
        FREDKIN = 2'd3
    } gate_op_e;

    // One gate word: opcode plus up to three bit indices into the state vector.
    typedef struct packed {
        gate_op_e           op;
        logic [IDX_W-1:0]   a;
        logic [IDX_W-1:0]   b;
        logic [IDX_W-1:0]   c;
    } gate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rev_gate_apply.sv
// Combinational application of one reversible gate to a state vector.
// A gate that names an out-of-range bit, or names the same bit twice among
// the indices it actually uses, passes the vector through unchanged.
module rev_gate_apply
    import rev_pkg::*;
#(
    parameter int WIDTH = REV_WIDTH
) (
    input  gate_t              gate_i,
    input  logic [WIDTH-1:0]   x_i,
    output logic [WIDTH-1:0]   x_o
);

    logic a_ok, b_ok, c_ok;
    logic ab_diff, ac_diff, bc_diff;

    assign a_ok    = (32'(gate_i.a) < WIDTH);
    assign b_ok    = (32'(gate_i.b) < WIDTH);
    assign c_ok    = (32'(gate_i.c) < WIDTH);
    assign ab_diff = (gate_i.a != gate_i.b);
    assign ac_diff = (gate_i.a != gate_i.c);
    assign bc_diff = (gate_i.b != gate_i.c);

    // Decode the opcode and modify only the target bit(s) of a legal gate.
    always_comb begin
        x_o = x_i;
        case (gate_i.op)
            NOT: begin
                if (a_ok)
                    x_o[gate_i.a] = ~x_i[gate_i.a];
            end
            CNOT: begin
                if (a_ok && b_ok && ab_diff)
                    x_o[gate_i.b] = x_i[gate_i.b] ^ x_i[gate_i.a];
            end
            TOFFOLI: begin
                if (a_ok && b_ok && c_ok && ab_diff && ac_diff && bc_diff)
                    x_o[gate_i.c] = x_i[gate_i.c] ^ (x_i[gate_i.a] & x_i[gate_i.b]);
            end
            FREDKIN: begin
                if (a_ok && b_ok && c_ok && ab_diff && ac_diff && bc_diff && x_i[gate_i.a]) begin
                    x_o[gate_i.b] = x_i[gate_i.c];
                    x_o[gate_i.c] = x_i[gate_i.b];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reversible_cascade_engine.sv
// Sequential reversible-cascade evaluator: one gate per clock from a small
// program memory, walked forward (slot 0 upward) or inverse (last slot down).
module reversible_cascade_engine
    import rev_pkg::*;
#(
    parameter int  WIDTH = REV_WIDTH,
    parameter int  DEPTH = REV_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  gate_t              prog_gate,
    input  logic               prog_len_we,
    input  logic [LW-1:0]      prog_len_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               dir_q, dir_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [LW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      len_sat;
    logic [WIDTH-1:0]   x_applied;
    logic               idle;
    gate_t              gate_mem [DEPTH];

    assign idle    = (state_q == IDLE);
    assign len_sat = (prog_len_in > LW'(DEPTH)) ? LW'(DEPTH) : prog_len_in;

    // Program memory: one write port per slot, only while idle; never reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (prog_we && idle && (prog_addr == AW'(gi)))
                gate_mem[gi] <= prog_gate;
        end
    end

    rev_gate_apply #(.WIDTH(WIDTH)) u_apply (
        .gate_i (gate_mem[pc_q]),
        .x_i    (x_q),
        .x_o    (x_applied)
    );

    // Program length: loaded only while idle, and not on the accept edge so a
    // run always uses the length that was in place before it was accepted.
    always_ff @(posedge clk) begin
        if (rst)
            len_q <= '0;
        else if (prog_len_we && idle && !in_valid)
            len_q <= len_sat;
    end

    // Engine state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            dir_q   <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            dir_q   <= dir_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, one gate per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        dir_d   = dir_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    dir_d   = in_dir;
                    cnt_d   = len_q;
                    pc_d    = in_dir ? AW'(len_q - LW'(1)) : '0;
                    state_d = (len_q != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                x_d   = x_applied;
                pc_d  = dir_q ? (pc_q - AW'(1)) : (pc_q + AW'(1));
                cnt_d = cnt_q - LW'(1);
                if (cnt_q == LW'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = idle;
    assign out_valid = (state_q == DONE);
    assign out_data  = x_q;

endmodule

// File: tb/tb_reversible_cascade_engine.sv
// Directed bench for the reversible cascade engine plus a random
// forward/inverse round-trip sweep.
module tb_reversible_cascade_engine;
    import rev_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         prog_we;
    logic [3:0]   prog_addr;
    gate_t        prog_gate;
    logic         prog_len_we;
    logic [4:0]   prog_len_in;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_dir;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;

    int checks = 0;
    int errors = 0;

    reversible_cascade_engine dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_gate   (prog_gate),
        .prog_len_we (prog_len_we),
        .prog_len_in (prog_len_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dir      (in_dir),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic gate_t mk(input gate_op_e op, input int a, input int b, input int c);
        gate_t g;
        g.op = op;
        g.a  = 3'(a);
        g.b  = 3'(b);
        g.c  = 3'(c);
        return g;
    endfunction

    task automatic write_gate(input int slot, input gate_t g);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 4'(slot);
        prog_gate = g;
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    task automatic write_len(input int len);
        @(negedge clk);
        prog_len_we = 1'b1;
        prog_len_in = 5'(len);
        @(posedge clk); #1;
        prog_len_we = 1'b0;
    endtask

    // Present one vector, wait for the result, accept it. lat counts edges
    // from the accept edge (inclusive) to the edge after which out_valid is seen.
    task automatic run(input logic [7:0] v, input logic dir,
                       output logic [7:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        in_dir   = dir;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        prog_we     = 1'b0;
        prog_len_we = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("run_timeout", 32'(out_valid), 32'd1);
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic load_base_program();
        write_gate(0, mk(FREDKIN, 0, 1, 2));
        write_gate(1, mk(CNOT, 3, 4, 0));
        write_gate(2, mk(TOFFOLI, 0, 3, 5));
        write_len(3);
    endtask

    initial begin
        logic [7:0] res, back, v, held;
        int lat;

        rst = 1'b1; prog_we = 0; prog_addr = 0; prog_gate = '0;
        prog_len_we = 0; prog_len_in = 0; in_valid = 0; in_data = 0;
        in_dir = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h00);

        // Base cascade, forward and inverse.
        load_base_program();
        run(8'h0D, 1'b0, res, lat);
        $display("fwd 0D -> %h lat %0d", res, lat);
        check("fwd_0D", 32'(res), 32'h3B);
        check("fwd_latency", 32'(lat), 32'd4);
        run(8'h3B, 1'b1, res, lat);
        $display("inv 3B -> %h lat %0d", res, lat);
        check("inv_3B", 32'(res), 32'h0D);
        check("inv_latency", 32'(lat), 32'd4);
        run(8'h0C, 1'b0, res, lat);
        $display("fwd 0C -> %h", res);
        check("fwd_0C_noswap", 32'(res), 32'h1C);

        // Empty program passes data through after one edge.
        write_len(0);
        run(8'hA5, 1'b0, res, lat);
        $display("len0 fwd A5 -> %h lat %0d", res, lat);
        check("len0_fwd", 32'(res), 32'hA5);
        check("len0_latency", 32'(lat), 32'd1);
        run(8'hA5, 1'b1, res, lat);
        $display("len0 inv A5 -> %h", res);
        check("len0_inv", 32'(res), 32'hA5);

        // Colliding indices make each gate a no-op.
        write_gate(0, mk(CNOT, 2, 2, 0));
        write_gate(1, mk(FREDKIN, 1, 4, 4));
        write_gate(2, mk(TOFFOLI, 0, 1, 0));
        write_len(3);
        run(8'hFF, 1'b0, res, lat);
        $display("collide FF -> %h", res);
        check("collision_noop", 32'(res), 32'hFF);

        // Single NOT on the top bit.
        write_gate(0, mk(NOT, 7, 0, 0));
        write_len(1);
        run(8'h00, 1'b0, res, lat);
        $display("not7 00 -> %h lat %0d", res, lat);
        check("not_bit7", 32'(res), 32'h80);
        check("len1_latency", 32'(lat), 32'd2);

        // Backpressure: result held, no new input accepted.
        load_base_program();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h0D; in_dir = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        held = out_data;
        check("bp_data", 32'(held), 32'h3B);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            $display("bp cycle %0d data %h in_ready %0d", i, out_data, in_ready);
            check("bp_hold_data", 32'(out_data), 32'h3B);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // A program write during RUN must be dropped.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h0D; in_dir = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd1; prog_gate = mk(NOT, 7, 0, 0);
        @(posedge clk); #1;
        prog_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("run_write_result", 32'(out_data), 32'h3B);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        run(8'h0D, 1'b0, res, lat);
        $display("after blocked write 0D -> %h", res);
        check("run_write_blocked", 32'(res), 32'h3B);

        // Same-cycle gate write lands; same-cycle length write is dropped.
        prog_we = 1'b1; prog_addr = 4'd2; prog_gate = mk(NOT, 7, 0, 0);
        prog_len_we = 1'b1; prog_len_in = 5'd0;
        run(8'h0D, 1'b0, res, lat);
        $display("same-cycle write 0D -> %h lat %0d", res, lat);
        check("samecycle_gate_new", 32'(res), 32'h9B);
        check("samecycle_len_old", 32'(lat), 32'd4);
        write_gate(2, mk(TOFFOLI, 0, 3, 5));
        run(8'h0D, 1'b0, res, lat);
        check("len_kept_after_drop", 32'(lat), 32'd4);
        check("restored_0D", 32'(res), 32'h3B);

        // Length saturates at DEPTH: 31 behaves as 16.
        write_len(31);
        run(8'h00, 1'b0, res, lat);
        $display("len31 lat %0d", lat);
        check("len_saturate", 32'(lat), 32'd17);
        write_len(3);

        // Reset during RUN cycle 2.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h0D; in_dir = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid-run reset: valid %0d data %h in_ready %0d", out_valid, out_data, in_ready);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        run(8'h5A, 1'b0, res, lat);
        check("rst_len0_data", 32'(res), 32'h5A);
        check("rst_len0_latency", 32'(lat), 32'd1);

        // Random programs: forward then inverse returns the original vector.
        for (int p = 0; p < 10; p++) begin
            int len;
            len = $urandom_range(1, 16);
            for (int s = 0; s < 16; s++)
                write_gate(s, mk(gate_op_e'($urandom_range(0, 3)), $urandom_range(0, 7),
                                 $urandom_range(0, 7), $urandom_range(0, 7)));
            write_len(len);
            for (int n = 0; n < 100; n++) begin
                v = 8'($urandom);
                run(v, 1'b0, res, lat);
                run(res, 1'b1, back, lat);
                $display("prog %0d len %0d vec %h fwd %h inv %h", p, len, v, res, back);
                check("roundtrip", 32'(back), 32'(v));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reversible_cascade_engine.md
# reversible_cascade_engine

Sequential evaluator for cascades of reversible gates (NOT, CNOT, Toffoli, Fredkin) over a WIDTH-bit state vector, applying one gate per clock from a small programmable gate list. It runs the cascade forward (gate 0 to last) or inverse (last to gate 0). Every gate is self-inverse, so the inverse run recovers the original input from a forward result. It is the decoder/uncompute counterpart to the combinational gate library.

## Interface
- WIDTH, 8: state vector width; gate indices are $clog2(WIDTH) bits.
- DEPTH, 16: maximum gates in the program.
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- prog_we  input  1  write one gate word; ignored unless the engine is IDLE.
- prog_addr  input  $clog2(DEPTH)  gate slot to write.
- prog_gate  input  2+3*$clog2(WIDTH)  packed gate_t {op, a, b, c}.
- prog_len_we  input  1  load prog_len; ignored unless IDLE.
- prog_len_in  input  $clog2(DEPTH)+1  number of active gates, 0..DEPTH; values above DEPTH saturate to DEPTH.
- in_valid  input  1  input vector valid.
- in_ready  output  1  high only in IDLE.
- in_data  input  WIDTH  vector to transform.
- in_dir  input  1  0 = forward, 1 = inverse; sampled with in_data.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  result vector.

## Operation
- Gate semantics on state x:
  - NOT: x[a] ^= 1.
  - CNOT: x[b] ^= x[a].
  - TOFFOLI: x[c] ^= x[a] & x[b].
  - FREDKIN: if x[a], swap x[b] and x[c].
- Indices are used only by the ops that reference them; unused fields are ignored.
- Any index ≥ WIDTH, or any collision among the indices the op uses, makes the gate a no-op.
- State machine:
  - IDLE: in_ready=1. On in_valid & in_ready, load x<=in_data, dir<=in_dir, pc<=(dir ? len-1 : 0), cnt<=len. Go to RUN if len>0, else to DONE.
  - RUN: each cycle, x<=apply(gate[pc], x); pc steps +1 (forward) or −1 (inverse); cnt−1. When cnt reaches 1, the final gate is applied and the next state is DONE.
  - DONE: out_valid=1, out_data=x. Go to IDLE on out_ready.
- prog_len is captured at accept. Program writes are blocked outside IDLE, so they cannot disturb a run.
- Gate memory is not reset. prog_len resets to 0.

## Timing
- Reset values:
  - state IDLE.
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, out_data=0.
  - prog_len=0, pc=0, cnt=0.
- Latency: out_valid rises len+1 clocks after the accept edge. With len=0, it rises 1 clock after accept and out_data=in_data.
- Backpressure: out_data and out_valid are held stable while out_valid & !out_ready.
- in_ready is low from the accept edge until the edge where out_valid & out_ready completes. There is no overlap; throughput is one vector per len+2 cycles.
- Same-cycle prog_we and in_valid in IDLE: the write lands, and the accepted run sees the new word. A prog_len_we in the same cycle does not take effect; the run uses the old prog_len.
- rst asserted in any state, including mid-RUN or DONE, returns all outputs to their reset values on the next edge and discards the vector.

## Structure
- Package rev_pkg holds:
  - gate_op_e enum: NOT=0, CNOT=1, TOFFOLI=2, FREDKIN=3.
  - gate_t packed struct.
  - state_e enum: IDLE, RUN, DONE.
- Sub-module rev_gate_apply: purely combinational (gate_t, x) -> x', including index-validity and collision checks. It is reusable by other blocks and unit-testable alone.
- Top level holds the FSM, gate register file, pc, cnt and handshake logic.

## Test plan
- Program [FREDKIN(0,1,2), CNOT(3,4), TOFFOLI(0,3,5)] with len=3:
  - Forward in_data=8'h0D: out_data=8'h3B, out_valid exactly 4 cycles after accept.
  - Inverse in_data=8'h3B: out_data=8'h0D.
- len=0 with in_data=8'hA5, either dir: out_data=8'hA5 one cycle after accept.
- Collision/invalid gates: CNOT(2,2), then FREDKIN(1,4,4), then TOFFOLI(0,1,0), on 8'hFF: out_data=8'hFF.
- Backpressure: out_ready held low 5 cycles. out_data is stable and in_ready stays 0; the edge with out_ready=1 returns to IDLE and in_ready=1 on the next cycle.
- rst pulsed at RUN cycle 2 of a 3-gate run: next cycle out_valid=0, out_data=0, in_ready=1, prog_len=0. A following accept with len=0 passes data through.
- Random program (len 1..16) with random vectors: forward then inverse returns the original for 1000 vectors. A prog_we issued during RUN does not change gate memory.
